pc_unit: RTL

- Parametrised program-counter unit for the Otter RISC-V core; next generation of the single-register PC mux.
- Sits at the head of fetch and drives the instruction-memory address.
- Adds the following over the current PC:
  - XLEN/reset-vector/alignment parameters.
  - Stall-safe redirect capture, so a redirect during a stall is not lost.
  - Misaligned-target detection.
  - A small return-address stack (RAS) that supplies the target for `ret`.

---
 rtl/pc_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program-counter unit for the Otter RISC-V fetch stage.
//               Selects the next PC from sequential/jump/branch/trap/RAS
//               sources. It captures redirects that arrive during a stall,
//               rejects misaligned targets, and keeps a small circular
//               return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_en,
    input  logic [2:0]      src_sel,
    input  logic [XLEN-1:0] jalr,
    input  logic [XLEN-1:0] branch,
    input  logic [XLEN-1:0] jal,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            ras_push,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] next_addr,
    output logic            misalign,
    output logic            pend_valid,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int             c_ALB   = (IALIGN == 2) ? 1 : 2;
    localparam int             c_PW    = $clog2(RAS_DEPTH);
    localparam logic [c_PW:0]  c_DEPTH = (c_PW+1)'(RAS_DEPTH);
    localparam logic [XLEN-1:0] c_ALB_MASK = {{(XLEN-c_ALB){1'b1}}, {c_ALB{1'b0}}};

    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_pend;
    logic            r_pend_valid;
    logic            r_misalign;
    logic [c_PW-1:0] r_top;
    logic [c_PW:0]   r_count;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];

    logic [XLEN-1:0] w_next;
    logic [XLEN-1:0] w_target;
    logic [c_PW-1:0] w_top_inc;
    logic            w_ras_nonempty;
    logic            w_checked;
    logic            w_mis;
    logic            w_redirect;
    logic            w_pop;
    logic            w_push;
    logic            w_swap;

    assign w_next         = r_addr + XLEN'(4);
    assign w_top_inc      = r_top + c_PW'(1);
    assign w_ras_nonempty = (r_count != '0);

    // Target mux: form the candidate next PC for the selected source.
    always_comb begin
        w_target = r_addr;
        case (src_sel)
            3'd0: w_target = w_next;
            3'd1: w_target = {jalr[XLEN-1:1], 1'b0};
            3'd2: w_target = branch;
            3'd3: w_target = jal;
            3'd4: w_target = {mtvec[XLEN-1:2], 2'b00};
            3'd5: w_target = mepc & c_ALB_MASK;
            3'd6: w_target = w_ras_nonempty ? r_ras[r_top] : {jalr[XLEN-1:1], 1'b0};
            default: w_target = r_addr;
        endcase
    end

    // Only computed-address sources can produce a misaligned target; trap
    // sources are masked above, so they are aligned by construction.
    assign w_checked  = (src_sel == 3'd1) || (src_sel == 3'd2) ||
                        (src_sel == 3'd3) || (src_sel == 3'd6);
    assign w_mis      = w_checked && (|w_target[c_ALB-1:0]);
    assign w_redirect = (src_sel != 3'd0) && (src_sel != 3'd7) && !w_mis;

    // RAS operations; a push together with a valid pop swaps the top entry.
    assign w_pop  = (src_sel == 3'd6) && w_ras_nonempty && !w_mis;
    assign w_push = ras_push && (src_sel != 3'd6);
    assign w_swap = ras_push && w_pop;

    // PC, pending redirect and misalign pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= RESET_VEC;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_misalign <= w_mis;
            if (!w_en) begin
                if (w_redirect) begin
                    r_pend       <= w_target;
                    r_pend_valid <= 1'b1;
                end
            end else if (w_redirect) begin
                r_addr       <= w_target;
                r_pend_valid <= 1'b0;
            end else if (r_pend_valid) begin
                r_addr       <= r_pend;
                r_pend_valid <= 1'b0;
            end else if (src_sel == 3'd0) begin
                r_addr <= w_next;
            end
        end
    end

    // RAS pointer and occupancy; frozen while fetch is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (w_en && !w_swap) begin
            if (w_push) begin
                r_top <= w_top_inc;
                if (r_count != c_DEPTH) begin
                    r_count <= r_count + (c_PW+1)'(1);
                end
            end else if (w_pop) begin
                r_top   <= r_top - c_PW'(1);
                r_count <= r_count - (c_PW+1)'(1);
            end
        end
    end

    // RAS storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_en && w_swap) begin
            r_ras[r_top] <= w_next;
        end else if (w_en && w_push) begin
            r_ras[w_top_inc] <= w_next;
        end
    end

    assign addr       = r_addr;
    assign next_addr  = w_next;
    assign misalign   = r_misalign;
    assign pend_valid = r_pend_valid;
    assign ras_empty  = (r_count == '0);
    assign ras_full   = (r_count == c_DEPTH);

endmodule
`default_nettype wire
